// File: rtl/proc_loader.sv
// proc_loader: streams a program into the processor instruction RAM, runs it, drains the pipeline and dumps r0..NREGS-1.
// Optional feature macro: LOADER_CHECKSUM_EN adds an XOR checksum of all accepted instruction words.
module proc_loader #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int MAX_WORDS    = 512,
    parameter int RUN_CYCLES   = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int NREGS        = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic              working,
    output logic [3:0]        rID,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_id,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W:0]   words_loaded
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_FLUSH    = 3'd2,
        S_RUN      = 3'd3,
        S_DRAIN    = 3'd4,
        S_DUMP_SET = 3'd5,
        S_DUMP_OUT = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam int K_W     = ADDR_W + 1;
    localparam int CNT_MAX = (RUN_CYCLES > DRAIN_CYCLES) ? RUN_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [K_W-1:0]   LAST_ADDR  = K_W'(MAX_WORDS - 1);
    localparam logic [K_W-1:0]   LAST_REG   = K_W'(NREGS - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t              state_r, state_s;
    logic [K_W-1:0]      k_r, k_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic                wr_r, wr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic [3:0]          rid_r, rid_s;
    logic                out_valid_r, out_valid_s;
    logic [DATA_W-1:0]   out_data_r, out_data_s;
    logic [3:0]          out_id_r, out_id_s;
    logic                out_last_r, out_last_s;
    logic                ovf_r, ovf_s;
    logic [K_W-1:0]      words_r, words_s;
    logic                in_ready_r, working_r, busy_r, done_r;
    logic                accept_s;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_r, csum_s;
`endif

    assign accept_s = in_valid & in_ready_r;

    // Next-state and next-output computation for the load/run/dump sequence
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        cnt_s       = cnt_r;
        addr_s      = addr_r;
        wr_s        = 1'b0;
        wdata_s     = wdata_r;
        rid_s       = rid_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_id_s    = out_id_r;
        out_last_s  = out_last_r;
        ovf_s       = ovf_r;
        words_s     = words_r;
`ifdef LOADER_CHECKSUM_EN
        csum_s      = csum_r;
`endif
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s = S_LOAD;
                    k_s     = {K_W{1'b0}};
                    ovf_s   = 1'b0;
                    words_s = {K_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                    csum_s  = {DATA_W{1'b0}};
`endif
                end else begin
                    state_s = state_r;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    wr_s    = 1'b1;
                    addr_s  = k_r[ADDR_W-1:0];
                    wdata_s = in_data;
                    k_s     = k_r + K_W'(1);
                    words_s = words_r + K_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_s  = csum_r ^ in_data;
`endif
                    // The last RAM slot closes the program even without in_last; no wrap.
                    if (in_last) begin
                        state_s = S_FLUSH;
                    end else if (k_r == LAST_ADDR) begin
                        ovf_s   = 1'b1;
                        state_s = S_FLUSH;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_FLUSH: begin
                state_s = S_RUN;
                addr_s  = {ADDR_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
            S_RUN: begin
                if (cnt_r == RUN_LAST) begin
                    state_s = S_DRAIN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_s = S_DUMP_SET;
                    cnt_s   = {CNT_W{1'b0}};
                    k_s     = {K_W{1'b0}};
                    rid_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            S_DUMP_SET: begin
                state_s     = S_DUMP_OUT;
                out_valid_s = 1'b1;
                out_data_s  = rdata;
                out_id_s    = k_r[3:0];
                out_last_s  = (k_r == LAST_REG);
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    if (k_r == LAST_REG) begin
                        state_s    = S_DONE;
                        rid_s      = 4'd0;
                        out_data_s = {DATA_W{1'b0}};
                        out_id_s   = 4'd0;
                        out_last_s = 1'b0;
                        addr_s     = {ADDR_W{1'b0}};
                        wdata_s    = {DATA_W{1'b0}};
                    end else begin
                        state_s = S_DUMP_SET;
                        k_s     = k_r + K_W'(1);
                        rid_s   = k_s[3:0];
                    end
                end else begin
                    state_s = S_DUMP_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            k_r         <= {K_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            wr_r        <= 1'b0;
            wdata_r     <= {DATA_W{1'b0}};
            rid_r       <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_id_r    <= 4'd0;
            out_last_r  <= 1'b0;
            ovf_r       <= 1'b0;
            words_r     <= {K_W{1'b0}};
            in_ready_r  <= 1'b0;
            working_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_r      <= {DATA_W{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            cnt_r       <= cnt_s;
            addr_r      <= addr_s;
            wr_r        <= wr_s;
            wdata_r     <= wdata_s;
            rid_r       <= rid_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_id_r    <= out_id_s;
            out_last_r  <= out_last_s;
            ovf_r       <= ovf_s;
            words_r     <= words_s;
            in_ready_r  <= (state_s == S_LOAD);
            working_r   <= (state_s == S_RUN);
            busy_r      <= (state_s != S_IDLE) && (state_s != S_DONE);
            done_r      <= (state_s == S_DONE);
`ifdef LOADER_CHECKSUM_EN
            csum_r      <= csum_s;
`endif
        end
    end

    assign in_ready     = in_ready_r;
    assign addr         = addr_r;
    assign wr           = wr_r;
    assign wdata        = wdata_r;
    assign working      = working_r;
    assign rID          = rid_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_id       = out_id_r;
    assign out_last     = out_last_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign ovf          = ovf_r;
    assign words_loaded = words_r;
`ifdef LOADER_CHECKSUM_EN
    assign checksum     = csum_r;
`endif

endmodule

// File: tb/tb_proc_loader.sv
// Self-checking bench for proc_loader: a default-size instance and a 4-word RAM instance share stimulus;
// results are checked against a high-level model of the load/run/dump sequence.
`timescale 1ns/1ps
module tb_proc_loader;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int RC   = 64;
    localparam int MAXA = 512;
    localparam int MAXB = 4;

    logic clock = 1'b0;
    logic reset, start, in_valid, in_last, out_ready, sel;
    logic [DW-1:0] in_data;
    logic start_a, start_b;

    logic          a_in_ready, a_wr, a_working, a_out_valid, a_out_last, a_busy, a_done, a_ovf;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_out_data, a_rdata;
    logic [3:0]    a_rID, a_out_id;
    logic [AW:0]   a_words;
    logic          b_in_ready, b_wr, b_working, b_out_valid, b_out_last, b_busy, b_done, b_ovf;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_out_data, b_rdata;
    logic [3:0]    b_rID, b_out_id;
    logic [AW:0]   b_words;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] a_csum, b_csum, m_csum;
    assign m_csum = sel ? b_csum : a_csum;
`endif

    logic [DW-1:0] regs [16];
    logic [DW-1:0] prog [20];
    int n_vec = 0;
    int n_err = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign a_rdata = regs[a_rID];
    assign b_rdata = regs[b_rID];

    wire          m_in_ready  = sel ? b_in_ready  : a_in_ready;
    wire          m_wr        = sel ? b_wr        : a_wr;
    wire [AW-1:0] m_addr      = sel ? b_addr      : a_addr;
    wire [DW-1:0] m_wdata     = sel ? b_wdata     : a_wdata;
    wire          m_working   = sel ? b_working   : a_working;
    wire          m_out_valid = sel ? b_out_valid : a_out_valid;
    wire [DW-1:0] m_out_data  = sel ? b_out_data  : a_out_data;
    wire [3:0]    m_out_id    = sel ? b_out_id    : a_out_id;
    wire          m_out_last  = sel ? b_out_last  : a_out_last;
    wire          m_busy      = sel ? b_busy      : a_busy;
    wire          m_done      = sel ? b_done      : a_done;
    wire          m_ovf       = sel ? b_ovf       : a_ovf;
    wire [AW:0]   m_words     = sel ? b_words     : a_words;

    always #5 clock = ~clock;

    proc_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXA), .RUN_CYCLES(RC)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .addr(a_addr), .wr(a_wr), .wdata(a_wdata),
        .working(a_working), .rID(a_rID), .rdata(a_rdata), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_id(a_out_id), .out_last(a_out_last),
        .busy(a_busy), .done(a_done), .ovf(a_ovf), .words_loaded(a_words)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(a_csum)
`endif
    );

    proc_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXB), .RUN_CYCLES(RC)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .addr(b_addr), .wr(b_wr), .wdata(b_wdata),
        .working(b_working), .rID(b_rID), .rdata(b_rdata), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_id(b_out_id), .out_last(b_out_last),
        .busy(b_busy), .done(b_done), .ovf(b_ovf), .words_loaded(b_words)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(b_csum)
`endif
    );

    task automatic load_directed_prog();
        logic [DW-1:0] tail [12];
        tail = '{32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000, 32'h21540000, 32'h22760000,
                 32'h20320000, 32'h23100000, 32'h20350000, 32'h21240000, 32'h23060000, 32'h22170000};
        for (int j = 0; j < 8; j++) prog[j] = 32'h10F00080 + (32'h00010001 * j);
        for (int j = 0; j < 12; j++) prog[8 + j] = tail[j];
    endtask

    // One full start/load/run/dump sequence; vmode 0=valid always, 1=alternating, 2=random.
    task automatic run_seq(input string tag, input int n, input bit last_en, input int vmode,
                           input int stall, input bit pulse, input int maxw);
        int i = 0, cyc = 0, wc = 0, scnt = 0, stab = 0, rdy_full = 0, first_wr = -1, last_wr = -1;
        int exp_m, csum_bad = 0;
        bit exp_ovf, done_seen = 1'b0, have_prev = 1'b0, seen_ov = 1'b0, pulsed2 = 1'b0;
        logic [DW-1:0] prev = '0, exp_csum = '0;
        int wa [$];
        logic [DW-1:0] wd [$];
        int did [$];
        logic [DW-1:0] ddat [$];
        bit dlast [$];
        exp_m   = (n < maxw) ? n : maxw;
        exp_ovf = (n > maxw) || (n == maxw && !last_en);
        for (int j = 0; j < exp_m; j++) exp_csum = exp_csum ^ prog[j];
        for (int j = 0; j < 16; j++) regs[j] = $urandom;
        while (cyc < 3000 && !done_seen) begin
            @(posedge clock); #1;
            start = (cyc == 0) || (pulse && cyc == 5) || (pulse && seen_ov && !pulsed2);
            if (pulse && seen_ov && !pulsed2) pulsed2 = 1'b1;
            if (i < n) begin
                in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
                in_data  = prog[i];
                in_last  = last_en && (i == n - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            out_ready = (scnt >= stall);
            @(negedge clock);
            if (m_wr) begin
                wa.push_back(int'(m_addr));
                wd.push_back(m_wdata);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (m_working) wc++;
            if (i >= exp_m && m_in_ready) rdy_full++;
            if (in_valid && m_in_ready) i++;
`ifdef LOADER_CHECKSUM_EN
            if (wc > 0 && m_csum !== exp_csum) csum_bad++;
`endif
            if (m_out_valid) begin
                seen_ov = 1'b1;
                if (have_prev && m_out_data !== prev) stab++;
                if (out_ready) begin
                    did.push_back(int'(m_out_id));
                    ddat.push_back(m_out_data);
                    dlast.push_back(m_out_last);
                    scnt = 0;
                    have_prev = 1'b0;
                end else begin
                    scnt++;
                    prev = m_out_data;
                    have_prev = 1'b1;
                end
            end
            if (cyc >= 1 && m_done) done_seen = 1'b1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;

        n_vec++; if (!done_seen) begin n_err++; $display("FAIL %s timeout: done=%0d want 1 within 3000 cycles", tag, m_done); end
        n_vec++; if (wa.size() != exp_m) begin n_err++; $display("FAIL %s write_count: got %0d want %0d", tag, wa.size(), exp_m); end
        for (int j = 0; j < wa.size() && j < exp_m; j++) begin
            n_vec++; if (wa[j] != j || wd[j] !== prog[j]) begin n_err++;
                $display("FAIL %s write[%0d]: got addr %0d data %08h want addr %0d data %08h", tag, j, wa[j], wd[j], j, prog[j]); end
        end
        if (vmode == 0) begin
            n_vec++; if (last_wr - first_wr != exp_m - 1) begin n_err++;
                $display("FAIL %s write_span: got %0d cycles want %0d", tag, last_wr - first_wr + 1, exp_m); end
        end
        n_vec++; if (m_words !== (AW+1)'(exp_m)) begin n_err++; $display("FAIL %s words_loaded: got %0d want %0d", tag, m_words, exp_m); end
        n_vec++; if (m_ovf !== exp_ovf) begin n_err++; $display("FAIL %s ovf: got %0d want %0d", tag, m_ovf, exp_ovf); end
        n_vec++; if (rdy_full != 0) begin n_err++; $display("FAIL %s in_ready_after_full: got %0d cycles want 0", tag, rdy_full); end
        n_vec++; if (wc != RC) begin n_err++; $display("FAIL %s working_cycles: got %0d want %0d", tag, wc, RC); end
        n_vec++; if (did.size() != 8) begin n_err++; $display("FAIL %s dump_count: got %0d want 8", tag, did.size()); end
        for (int j = 0; j < did.size() && j < 8; j++) begin
            n_vec++; if (did[j] != j || ddat[j] !== regs[j] || dlast[j] != (j == 7)) begin n_err++;
                $display("FAIL %s dump[%0d]: got id %0d data %08h last %0d want id %0d data %08h last %0d",
                         tag, j, did[j], ddat[j], dlast[j], j, regs[j], (j == 7)); end
        end
        n_vec++; if (stab != 0) begin n_err++; $display("FAIL %s out_data_stable: got %0d changes want 0", tag, stab); end
        n_vec++; if (m_busy !== 1'b0 || m_done !== 1'b1 || m_out_valid !== 1'b0 || m_working !== 1'b0) begin n_err++;
            $display("FAIL %s done_state: got busy %0d done %0d out_valid %0d working %0d want 0 1 0 0",
                     tag, m_busy, m_done, m_out_valid, m_working); end
`ifdef LOADER_CHECKSUM_EN
        n_vec++; if (csum_bad != 0 || m_csum !== exp_csum) begin n_err++;
            $display("FAIL %s checksum: got %08h (%0d bad cycles) want %08h", tag, m_csum, csum_bad, exp_csum); end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_vec++; if ({a_in_ready, a_wr, a_addr, a_wdata, a_working, a_rID, a_out_valid, a_out_data, a_out_id,
                      a_out_last, a_busy, a_done, a_ovf, a_words} !== '0) begin n_err++;
            $display("FAIL reset_a: got nonzero outputs busy %0d done %0d words %0d want all 0", a_busy, a_done, a_words); end
        n_vec++; if ({b_in_ready, b_wr, b_working, b_out_valid, b_busy, b_done, b_ovf, b_words} !== '0) begin n_err++;
            $display("FAIL reset_b: got nonzero outputs busy %0d done %0d want all 0", b_busy, b_done); end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        n_vec++; if ({a_busy, a_done, a_in_ready, a_working} !== 4'b0000) begin n_err++;
            $display("FAIL idle_after_reset: got %b want 0000", {a_busy, a_done, a_in_ready, a_working}); end
    endtask

    task automatic test_directed();
        load_directed_prog();
        sel = 1'b0;
        run_seq("directed", 20, 1'b1, 0, 0, 1'b0, MAXA);
    endtask

    task automatic test_stall();
        load_directed_prog();
        sel = 1'b0;
        run_seq("stall", 20, 1'b1, 1, 3, 1'b0, MAXA);
    endtask

    task automatic test_start_ignored();
        load_directed_prog();
        sel = 1'b0;
        run_seq("start_ignored", 20, 1'b1, 0, 2, 1'b1, MAXA);
    endtask

    task automatic test_overflow();
        for (int j = 0; j < 6; j++) prog[j] = $urandom;
        sel = 1'b1;
        run_seq("overflow", 6, 1'b0, 0, 0, 1'b0, MAXB);
        sel = 1'b0;
    endtask

    task automatic test_reset_run();
        int wc = 0, cyc = 0;
        for (int j = 0; j < 3; j++) prog[j] = $urandom;
        sel = 1'b0;
        while (cyc < 500 && wc < 10) begin
            @(posedge clock); #1;
            start    = (cyc == 0);
            in_valid = (cyc < 3);
            in_data  = prog[cyc % 3];
            in_last  = (cyc == 2);
            @(negedge clock);
            if (a_working) wc++;
            cyc++;
        end
        n_vec++; if (wc != 10) begin n_err++; $display("FAIL reset_run_reach: got %0d working cycles want 10", wc); end
        @(posedge clock); #1;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        n_vec++; if ({a_working, a_busy, a_out_valid, a_done, a_wr} !== 5'b00000) begin n_err++;
            $display("FAIL reset_run_state: got working/busy/out_valid/done/wr %b want 00000",
                     {a_working, a_busy, a_out_valid, a_done, a_wr}); end
        n_vec++; if (a_words !== '0) begin n_err++; $display("FAIL reset_run_words: got %0d want 0", a_words); end
        run_seq("after_reset", 3, 1'b1, 0, 1, 1'b0, MAXA);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int j = 0; j < 20; j++) prog[j] = $urandom;
            run_seq("random", n, 1'b1, 2, $urandom_range(0, 3), 1'b0, MAXA);
        end
    endtask

    task automatic test_back_to_back();
        prog[0] = $urandom;
        run_seq("single_word", 1, 1'b1, 0, 0, 1'b0, MAXA);
        for (int j = 0; j < 4; j++) prog[j] = $urandom;
        sel = 1'b1;
        run_seq("exact_fill", 4, 1'b1, 0, 0, 1'b0, MAXB);
        sel = 1'b0;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        prog[0] = 32'h10F00080;
        prog[1] = 32'h10F10081;
        run_seq("checksum", 2, 1'b1, 0, 0, 1'b0, MAXA);
        n_vec++; if (a_csum !== 32'h00010001) begin n_err++; $display("FAIL checksum_const: got %08h want 00010001", a_csum); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_data = '0; sel = 1'b0;
        for (int j = 0; j < 16; j++) regs[j] = '0;
        test_reset();
        test_directed();
        test_stall();
        test_start_ignored();
        test_overflow();
        test_reset_run();
        test_random();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/proc_loader.md
Name: proc_loader

Overview:
- Host-side controller for the pipelined processor's external program/debug interface.
- Takes an instruction stream on a valid/ready input and writes it word-by-word into the processor's instruction RAM (drives addr/wr/wdata).
- Then asserts working for a programmed number of cycles and waits for the pipeline to drain.
- Finally reads r0..r7 back through rID/rdata and emits them on a valid/ready output stream.

Parameters:
ADDR_W, 9, instruction RAM address width
DATA_W, 32, instruction/register word width
MAX_WORDS, 512, RAM depth; last writable address is MAX_WORDS-1
RUN_CYCLES, 64, clock cycles working is held high
DRAIN_CYCLES, 4, idle cycles after working falls before register dump (covers decode/execute/write-back in flight)
NREGS, 8, number of registers dumped (rID 0..NREGS-1)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  single-cycle pulse begins a load/run/dump sequence; ignored while busy=1
in_valid  input  1  instruction word valid
in_ready  output  1  loader accepts a word this cycle
in_data  input  DATA_W  instruction word
in_last  input  1  marks final instruction of the program
addr  output  ADDR_W  to processor addr
wr  output  1  to processor wr
wdata  output  DATA_W  to processor wdata
working  output  1  to processor working
rID  output  4  to processor rID
rdata  input  DATA_W  from processor rdata (combinational on rID)
out_valid  output  1  dumped register word valid
out_ready  input  1  downstream accepts dumped word
out_data  output  DATA_W  dumped register value
out_id  output  4  register index of out_data
out_last  output  1  high with the word for register NREGS-1
busy  output  1  high from start accept until DONE
done  output  1  high in DONE; cleared by next accepted start
ovf  output  1  sticky; program truncated at MAX_WORDS; cleared by next accepted start
words_loaded  output  ADDR_W+1  count of words written this sequence

Behaviour:
- Reset (sync, active-high, takes priority in any state, including mid-load/run/dump): state=IDLE; all outputs 0; internal counters 0. An aborted sequence is abandoned; no partial dump is emitted.
- States: IDLE, LOAD, FLUSH, RUN, DRAIN, DUMP_SET, DUMP_OUT, DONE.
- IDLE/DONE: start=1 -> LOAD; busy=1, done=0, ovf=0, words_loaded=0, index k=0.
- LOAD: in_ready=1. Accept = in_valid&in_ready.
  - Next cycle after accept: wr=1, addr=k, wdata=in_data (registered, 1-cycle latency); k++, words_loaded++.
  - wr=0 in any cycle without a preceding accept. Back-to-back accepts give consecutive 1-cycle wr pulses.
- Leaving LOAD:
  - Accept with in_last=1 -> FLUSH.
  - Accept at k=MAX_WORDS-1 with in_last=0 -> ovf=1, FLUSH. No address wrap; further words are not accepted.
- FLUSH (1 cycle): in_ready=0; the final write is visible. Then -> RUN.
- RUN: wr=0, addr=0, working=1 for exactly RUN_CYCLES cycles, then working=0 -> DRAIN.
- DRAIN: DRAIN_CYCLES cycles with working=0, wr=0 -> DUMP_SET with k=0.
- DUMP_SET (1 cycle): rID=k.
- DUMP_OUT: out_data<=rdata captured on entry, out_id=k, out_last=(k==NREGS-1), out_valid=1.
  - rID held at k; out_data/out_id held stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid=0; if k==NREGS-1 -> DONE, else k++ -> DUMP_SET.
- DONE: busy=0, done=1; outputs other than done/ovf/words_loaded return to 0.
- start while busy=1 is ignored, with no side effect.
- Minimum program is 1 word (in_last on first accept). Zero-word programs are not expressible.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: adds output checksum (DATA_W). It is cleared to 0 on accepted start and XOR-accumulates every accepted in_data. Value is final from FLUSH onward and held through DONE until the next start. Reset clears it.
- Undefined: no checksum port or logic.

Test Plan:
- 20-word program (10F00080..10F70087, 20010000, 21230000, 22450000, 23670000, 21540000, 22760000, 20320000, 23100000, 20350000, 21240000, 23060000, 22170000), in_valid always 1, last on word 20 -> wr pulses at addr 0..19 with matching wdata on 20 consecutive cycles, words_loaded=20, working high exactly 64 cycles, 8 dump words out_id 0..7 with out_last on id 7, done=1, ovf=0.
- Same program with in_valid toggling 1/0 and out_ready low 3 cycles per word -> identical RAM write sequence and dump values; out_data stable while stalled.
- MAX_WORDS=4, 6 words sent without in_last -> exactly 4 writes (addr 0..3), ovf=1, in_ready=0 after 4th accept, sequence completes normally.
- Reset asserted during RUN (cycle 10 of 64) -> next cycle working=0, busy=0, out_valid=0; a new start then runs a full clean sequence.
- start pulsed during LOAD and during DUMP_OUT -> ignored; words_loaded and k unaffected.
- LOADER_CHECKSUM_EN defined, words 10F00080, 10F10081 -> checksum=00010001 from FLUSH through DONE.
